// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and the IF/ID register, sequencing fetches against a
// variable-latency instruction memory with redirect, stall and halt handling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request at pc, expecting a single-cycle hit
// S_WAIT  | miss outstanding, address held until imem_rdy
// S_REDIR | redirect captured during a miss, draining the old request
// S_HALT  | HLT retired, no requests until reset
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        hlt_dec,
  output logic [15:0] pc_out,
  output logic [15:0] instr_id,
  output logic [15:0] pcp2_id,
  output logic        valid_id,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_REDIR, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic [15:0] r_pcp2, w_pcp2_nxt;
  logic [15:0] r_redir_pc, w_redir_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_halted, w_halted_nxt;
  logic        r_halt_pend, w_halt_pend_nxt;

  logic [15:0] w_pc_inc;
  logic [15:0] w_target;
  logic        w_br;
  logic        w_hlt;

  assign w_pc_inc = r_pc + PC_INC;
  assign w_target = {br_target[15:1], 1'b0};
  // Stall masks decode events; decode re-presents them once the stall clears.
  assign w_br     = br_taken & ~stall;
  assign w_hlt    = hlt_dec & ~stall;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    w_pcp2_nxt      = r_pcp2;
    w_redir_pc_nxt  = r_redir_pc;
    w_valid_nxt     = r_valid;
    w_halted_nxt    = r_halted;
    w_halt_pend_nxt = r_halt_pend;
    case (r_state)
      S_FETCH, S_WAIT: begin
        if (imem_rdy) begin
          if (r_state == S_WAIT && r_halt_pend) begin
            w_state_nxt     = S_HALT;
            w_valid_nxt     = 1'b0;
            w_halted_nxt    = 1'b1;
            w_halt_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = S_FETCH;
            if (!stall) begin
              if (w_br) begin
                w_pc_nxt    = w_target;
                w_valid_nxt = 1'b0;
              end else if (w_hlt) begin
                w_state_nxt  = S_HALT;
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b1;
              end else begin
                w_instr_nxt = imem_data;
                w_pcp2_nxt  = w_pc_inc;
                w_valid_nxt = 1'b1;
                w_pc_nxt    = w_pc_inc;
              end
            end
          end
        end else begin
          w_state_nxt = S_WAIT;
          if (!stall) begin
            w_valid_nxt = 1'b0;
            if (w_br) begin
              w_redir_pc_nxt  = w_target;
              w_state_nxt     = S_REDIR;
              w_halt_pend_nxt = 1'b0;
            end else if (w_hlt) begin
              w_halt_pend_nxt = 1'b1;
            end
          end
        end
      end
      S_REDIR: begin
        w_valid_nxt = 1'b0;
        if (w_br) w_redir_pc_nxt = w_target;
        if (imem_rdy) begin
          w_pc_nxt    = w_br ? w_target : r_redir_pc;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= 16'h0000;
      r_pcp2      <= 16'h0000;
      r_redir_pc  <= 16'h0000;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_pcp2      <= w_pcp2_nxt;
      r_redir_pc  <= w_redir_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_halted    <= w_halted_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  assign imem_req  = ~rst & (r_state != S_HALT);
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign instr_id  = r_instr;
  assign pcp2_id   = r_pcp2;
  assign valid_id  = r_valid;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a flag-based reference model queues the expected
// per-cycle outputs and a negedge monitor pops and compares them.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, imem_rdy, stall, br_taken, hlt_dec;
  logic [15:0] imem_data, br_target;
  logic        imem_req, valid_id, halted;
  logic [15:0] imem_addr, pc_out, instr_id, pcp2_id;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(16'h0000), .PC_INC(16'h0002)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .hlt_dec(hlt_dec),
    .pc_out(pc_out), .instr_id(instr_id), .pcp2_id(pcp2_id),
    .valid_id(valid_id), .halted(halted)
  );

  typedef struct {
    logic        req;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcp2;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: architectural pc plus "redirect draining" / "halt pending" flags.
  logic [15:0] m_pc, m_instr, m_pcp2, m_redir_pc;
  logic        m_valid, m_halted, m_in_redir, m_halt_pend;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t,
                      input logic h, input logic rdy, input logic [15:0] d);
    exp_t e;
    rst = r; stall = s; br_taken = b; br_target = t; hlt_dec = h;
    imem_rdy = rdy; imem_data = d;
    e.req = !r && !m_halted;
    e.pc = m_pc; e.instr = m_instr; e.pcp2 = m_pcp2;
    e.valid = m_valid; e.halted = m_halted;
    q.push_back(e);
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pcp2 = 16'h0000; m_redir_pc = 16'h0000;
      m_valid = 0; m_halted = 0; m_in_redir = 0; m_halt_pend = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (m_in_redir) begin
      m_valid = 0;
      if (!s && b) m_redir_pc = t & 16'hFFFE;
      if (rdy) begin
        m_pc = m_redir_pc;
        m_in_redir = 0;
      end
    end else if (rdy) begin
      if (m_halt_pend) begin
        m_halted = 1; m_valid = 0; m_halt_pend = 0;
      end else if (!s) begin
        if (b) begin
          m_pc = t & 16'hFFFE; m_valid = 0;
        end else if (h) begin
          m_halted = 1; m_valid = 0;
        end else begin
          m_instr = d; m_pcp2 = m_pc + 16'd2; m_valid = 1; m_pc = m_pc + 16'd2;
        end
      end
    end else if (!s) begin
      m_valid = 0;
      if (b) begin
        m_redir_pc = t & 16'hFFFE; m_in_redir = 1; m_halt_pend = 0;
      end else if (h) begin
        m_halt_pend = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hit();
    step(0, 0, 0, 16'h0, 0, 1, 16'($urandom));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_req", {15'b0, imem_req}, {15'b0, e.req});
      chk("imem_addr", imem_addr, e.pc);
      chk("pc_out", pc_out, e.pc);
      chk("valid_id", {15'b0, valid_id}, {15'b0, e.valid});
      chk("halted", {15'b0, halted}, {15'b0, e.halted});
      if (e.valid) begin
        chk("instr_id", instr_id, e.instr);
        chk("pcp2_id", pcp2_id, e.pcp2);
      end
    end
  end

  initial begin
    rst = 1; stall = 0; br_taken = 0; br_target = 0; hlt_dec = 0; imem_rdy = 0; imem_data = 0;
    m_pc = 0; m_instr = 0; m_pcp2 = 0; m_redir_pc = 0;
    m_valid = 0; m_halted = 0; m_in_redir = 0; m_halt_pend = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    // sequential hits, then a two-cycle stall at 0x0006
    for (int i = 0; i < 3; i++) hit();
    step(0, 1, 0, 16'h0, 0, 1, 16'hDEAD);
    step(0, 1, 1, 16'h0200, 1, 1, 16'hBEEF);
    for (int i = 0; i < 16 && m_pc != 16'h0010; i++) hit();
    // branch masked by stall, then taken branch with odd target
    step(0, 1, 1, 16'h0041, 0, 1, 16'h1111);
    step(0, 0, 1, 16'h0041, 0, 1, 16'h2222);
    hit(); hit();
    step(0, 0, 1, 16'h0020, 0, 1, 16'h3333);
    // 3-cycle miss at 0x0020 with a redirect in the second wait cycle
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0100, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 0, 1, 16'h4444);
    hit(); hit();
    // HLT during a miss
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0, 0, 1, 16'h5555);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 0, 1, 16'($urandom));
    step(1, 0, 0, 16'h0, 0, 1, 16'h0);
    hit(); hit();
    // wrap at 0xFFFE, then reset in the middle of a miss
    step(0, 0, 1, 16'hFFFF, 0, 1, 16'h0);
    hit(); hit();
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 0, 1, 16'h6666);
    hit();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           16'($urandom),
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 2) != 0,
           16'($urandom));
    end
    step(0, 0, 0, 16'h0, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
